// File: rtl/s1488_resp_capture_if.sv
// Response-capture bus: sample input plus the valid/ready drain of captured events.
interface s1488_resp_capture_if #(
  parameter int TS_W = 12
);
  logic             in_en;
  logic [18:0]      d_in;
  logic             out_valid;
  logic             out_ready;
  logic [18:0]      out_data;
  logic [TS_W-1:0]  out_stamp;

  modport master (
    output in_en, d_in, out_ready,
    input  out_valid, out_data, out_stamp
  );

  modport slave (
    input  in_en, d_in, out_ready,
    output out_valid, out_data, out_stamp
  );
endinterface

// File: rtl/s1488_resp_capture.sv
// Captures s1488 output vectors: 19-bit MISR signature plus a FWFT FIFO of
// change events, each tagged with its sample timestamp.
module s1488_resp_capture #(
  parameter int          DEPTH = 8,
  parameter int          TS_W  = 12,
  parameter logic [18:0] POLY  = 19'h00027
) (
  input  logic                     CK,
  input  logic                     CLR,
  s1488_resp_capture_if.slave      bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [18:0]              sig
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [18:0] misr_step(input logic [18:0] s, input logic [18:0] d);
    logic [18:0] n;
    n[0] = s[18] ^ d[0];
    for (int i = 1; i < 19; i++) n[i] = s[i-1] ^ d[i] ^ (POLY[i] & s[18]);
    return n;
  endfunction

  logic [18:0]     r_mem_data  [DEPTH];
  logic [TS_W-1:0] r_mem_stamp [DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [18:0]     r_prev, r_sig, r_last_data;
  logic [TS_W-1:0] r_stamp, r_last_stamp;
  logic            r_first, r_ovf;

  logic w_full, w_pop, w_event, w_push, w_drop;

  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_pop   = (r_count != '0) && bus.out_ready;
    w_event = bus.in_en && (r_first || (bus.d_in != r_prev));
    w_push  = w_event && (!w_full || w_pop);
    w_drop  = w_event && !w_push;
  end

  // Control state: pointers, occupancy, change detect, timestamp, signature
  always_ff @(posedge CK) begin
    if (CLR) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_prev       <= '0;
      r_first      <= 1'b1;
      r_stamp      <= '0;
      r_sig        <= '0;
      r_ovf        <= 1'b0;
      r_last_data  <= '0;
      r_last_stamp <= '0;
    end else begin
      if (bus.in_en) begin
        r_prev  <= bus.d_in;
        r_first <= 1'b0;
        r_stamp <= r_stamp + TS_W'(1);
        r_sig   <= misr_step(r_sig, bus.d_in);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + AW'(1);
        r_last_data  <= r_mem_data[r_rd_ptr];
        r_last_stamp <= r_mem_stamp[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage carries no reset; an empty FIFO shows the last popped entry instead
  always_ff @(posedge CK) begin
    if (!CLR && w_push) begin
      r_mem_data[r_wr_ptr]  <= bus.d_in;
      r_mem_stamp[r_wr_ptr] <= r_stamp;
    end
  end

  always_comb begin
    bus.out_valid = (r_count != '0);
    bus.out_data  = bus.out_valid ? r_mem_data[r_rd_ptr]  : r_last_data;
    bus.out_stamp = bus.out_valid ? r_mem_stamp[r_rd_ptr] : r_last_stamp;
    fifo_count    = r_count;
    overflow      = r_ovf;
    sig           = r_sig;
  end
endmodule
